// File: rtl/proc_pkg.sv
// Shared opcodes, controller step encoding and bus-select codes for multicycle_proc.
package proc_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    typedef enum logic [1:0] {
        BUS_ZERO = 2'd0,
        BUS_REG  = 2'd1,
        BUS_DIN  = 2'd2,
        BUS_G    = 2'd3
    } bus_sel_e;

endpackage

// File: rtl/proc_regfile.sv
// General register file: one synchronous write port, one combinational read port.
module proc_regfile #(
    parameter int REG_WIDTH  = 16,
    parameter int NUM_REGS   = 8,
    parameter int RIDX_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [RIDX_WIDTH-1:0] waddr,
    input  logic [REG_WIDTH-1:0]  wdata,
    input  logic [RIDX_WIDTH-1:0] raddr,
    output logic [REG_WIDTH-1:0]  rdata
);

    logic [REG_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/multicycle_proc.sv
// Multi-cycle mv/mvi/add/sub core on a single shared bus.
// Define MULTICYCLE_PROC_FLAGS_EN to add zero/carry flag outputs.
module multicycle_proc
    import proc_pkg::*;
#(
    parameter  int REG_WIDTH         = 16,
    parameter  int NUM_REGS          = 8,
    localparam int RIDX_WIDTH        = $clog2(NUM_REGS),
    localparam int INSTRUCTION_WIDTH = 3 + 2*RIDX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [REG_WIDTH-1:0] din,
    output logic [REG_WIDTH-1:0] bus,
    output logic                 done,
    output logic                 busy
`ifdef MULTICYCLE_PROC_FLAGS_EN
    ,
    output logic                 flag_z,
    output logic                 flag_c
`endif
);

    step_e                        t, t_next;
    bus_sel_e                     bus_sel;
    logic [INSTRUCTION_WIDTH-1:0] ir;
    logic [REG_WIDTH-1:0]         a, g, g_next, rdata;
    logic [RIDX_WIDTH-1:0]        raddr;
    logic                         rf_we, ir_ld, a_ld, g_ld;
    logic [2:0]                   opcode;
    logic [RIDX_WIDTH-1:0]        rx, ry;

    assign opcode = ir[INSTRUCTION_WIDTH-1 -: 3];
    assign rx     = ir[2*RIDX_WIDTH-1 -: RIDX_WIDTH];
    assign ry     = ir[RIDX_WIDTH-1:0];

    proc_regfile #(
        .REG_WIDTH (REG_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .RIDX_WIDTH(RIDX_WIDTH)
    ) u_regfile (
        .clk  (clk),
        .rst  (rst),
        .we   (rf_we),
        .waddr(rx),
        .wdata(bus),
        .raddr(raddr),
        .rdata(rdata)
    );

    always_comb begin
        t_next  = t;
        bus_sel = BUS_ZERO;
        raddr   = ry;
        done    = 1'b0;
        rf_we   = 1'b0;
        ir_ld   = 1'b0;
        a_ld    = 1'b0;
        g_ld    = 1'b0;
        case (t)
            T0: begin
                if (run) begin
                    ir_ld  = 1'b1;
                    t_next = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        bus_sel = BUS_REG;
                        done    = 1'b1;
                        rf_we   = 1'b1;
                        t_next  = T0;
                    end
                    OP_MVI: begin
                        bus_sel = BUS_DIN;
                        done    = 1'b1;
                        rf_we   = 1'b1;
                        t_next  = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_sel = BUS_REG;
                        raddr   = rx;
                        a_ld    = 1'b1;
                        t_next  = T2;
                    end
                    default: begin
                        // Reserved opcodes retire as a one-step NOP.
                        done   = 1'b1;
                        t_next = T0;
                    end
                endcase
            end
            T2: begin
                bus_sel = BUS_REG;
                g_ld    = 1'b1;
                t_next  = T3;
            end
            T3: begin
                bus_sel = BUS_G;
                done    = 1'b1;
                rf_we   = 1'b1;
                t_next  = T0;
            end
            default: t_next = T0;
        endcase
    end

    always_comb begin
        case (bus_sel)
            BUS_REG: bus = rdata;
            BUS_DIN: bus = din;
            BUS_G:   bus = g;
            default: bus = '0;
        endcase
    end

    assign g_next = (opcode == OP_SUB) ? (a - bus) : (a + bus);

    always_ff @(posedge clk) begin
        if (rst) begin
            t    <= T0;
            busy <= 1'b0;
            ir   <= '0;
            a    <= '0;
            g    <= '0;
        end else begin
            t    <= t_next;
            busy <= (t_next != T0);
            if (ir_ld) ir <= din[INSTRUCTION_WIDTH-1:0];
            if (a_ld)  a  <= bus;
            if (g_ld)  g  <= g_next;
        end
    end

`ifdef MULTICYCLE_PROC_FLAGS_EN
    // Add carries out exactly when the wrapped sum is smaller than an operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (g_ld) begin
            flag_z <= (g_next == '0);
            flag_c <= (opcode == OP_SUB) ? (a < bus) : (g_next < a);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_proc.sv
// Self-checking bench for multicycle_proc: directed plan plus random instruction stream.
module tb_multicycle_proc;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] din;
    logic [15:0] bus;
    logic        done;
    logic        busy;
`ifdef MULTICYCLE_PROC_FLAGS_EN
    logic        flag_z, flag_c;
    logic        mz, mc;
`endif

    int checks = 0;
    int passed = 0;
    int failed = 0;

    logic [15:0] m [8];

    always #5 clk = ~clk;

    multicycle_proc #(.REG_WIDTH(16), .NUM_REGS(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .din   (din),
        .bus   (bus),
        .done  (done),
        .busy  (busy)
`ifdef MULTICYCLE_PROC_FLAGS_EN
        ,
        .flag_z(flag_z),
        .flag_c(flag_c)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m[i] = 16'h0;
`ifdef MULTICYCLE_PROC_FLAGS_EN
        mz = 1'b0;
        mc = 1'b0;
`endif
    endtask

    // Runs one instruction; drop_step releases run, abort_step pulses rst at that step.
    task automatic exec(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                        input logic [15:0] imm, input int drop_step, input int abort_step);
        logic [31:0] r;
        logic [15:0] exp_bus;
        logic        exp_done;
        logic [15:0] res;
        int          nsteps;
        bit          arith;
        arith  = (op == 3'b010) || (op == 3'b011);
        nsteps = arith ? 3 : 1;
        res    = (op == 3'b011) ? 16'((int'(m[x]) - int'(m[y])) % 65536) : 16'((int'(m[x]) + int'(m[y])) % 65536);
        r = $urandom;
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        din = {r[6:0], op, x, y};
        #1;
        check("t0_bus", 32'(bus), 32'h0);
        check("t0_done", 32'(done), 32'h0);
        check("t0_busy", 32'(busy), 32'h0);
        @(posedge clk);
        for (int s = 1; s <= nsteps; s++) begin
            r = $urandom;
            @(negedge clk);
            din = (op == 3'b001) ? imm : r[15:0];
            if (s == drop_step) run = 1'b0;
            if (s == abort_step) rst = 1'b1;
            #1;
            if (s != abort_step) begin
                exp_done = (s == nsteps);
                if (op == 3'b000)      exp_bus = m[y];
                else if (op == 3'b001) exp_bus = imm;
                else if (!arith)       exp_bus = 16'h0;
                else if (s == 1)       exp_bus = m[x];
                else if (s == 2)       exp_bus = m[y];
                else                   exp_bus = res;
                check($sformatf("op%0d_t%0d_bus", op, s), 32'(bus), 32'(exp_bus));
                check($sformatf("op%0d_t%0d_done", op, s), 32'(done), 32'(exp_done));
                check($sformatf("op%0d_t%0d_busy", op, s), 32'(busy), 32'h1);
`ifdef MULTICYCLE_PROC_FLAGS_EN
                check($sformatf("op%0d_t%0d_flag_z", op, s), 32'(flag_z), 32'(mz));
                check($sformatf("op%0d_t%0d_flag_c", op, s), 32'(flag_c), 32'(mc));
`endif
            end
            @(posedge clk);
            if (s == abort_step) begin
                model_clear();
                return;
            end
`ifdef MULTICYCLE_PROC_FLAGS_EN
            if (arith && s == 2) begin
                mz = (res == 16'h0);
                mc = (op == 3'b011) ? (m[x] < m[y]) : ((int'(m[x]) + int'(m[y])) > 65535);
            end
`endif
        end
        if (op == 3'b000)      m[x] = m[y];
        else if (op == 3'b001) m[x] = imm;
        else if (arith)        m[x] = res;
    endtask

    task automatic ex(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y, input logic [15:0] imm);
        exec(op, x, y, imm, 0, 0);
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1;
        run = 1'b0;
        din = 16'h0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus", 32'(bus), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        ex(3'b001, 3'd0, 3'd0, 16'h0005);
        ex(3'b000, 3'd1, 3'd0, 16'h0);
        ex(3'b001, 3'd2, 3'd0, 16'h00A5);
        ex(3'b001, 3'd3, 3'd0, 16'h0010);
        ex(3'b010, 3'd2, 3'd3, 16'h0);
        ex(3'b000, 3'd4, 3'd2, 16'h0);
        check("add_result_b5", 32'(m[4]), 32'h00B5);
        ex(3'b001, 3'd5, 3'd0, 16'h0003);
        ex(3'b001, 3'd6, 3'd0, 16'h0005);
        ex(3'b011, 3'd5, 3'd6, 16'h0);
        ex(3'b001, 3'd7, 3'd0, 16'hFFFF);
        ex(3'b010, 3'd7, 3'd7, 16'h0);
        ex(3'b011, 3'd7, 3'd7, 16'h0);

        @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_bus", 32'(bus), 32'h0);
            check("idle_done", 32'(done), 32'h0);
        end

        ex(3'b001, 3'd0, 3'd0, 16'h1234);
        ex(3'b001, 3'd1, 3'd0, 16'h0101);
        exec(3'b010, 3'd0, 3'd1, 16'h0, 2, 0);
        ex(3'b000, 3'd3, 3'd0, 16'h0);
        ex(3'b111, 3'd2, 3'd4, 16'h0);
        for (int i = 0; i < 8; i++) ex(3'b000, 3'(i), 3'(i), 16'h0);

        exec(3'b010, 3'd0, 3'd1, 16'h0, 0, 2);
        ex(3'b000, 3'd2, 3'd0, 16'h0);
        ex(3'b000, 3'd3, 3'd1, 16'h0);

        for (int i = 0; i < 60; i++) begin
            r = $urandom;
            ex(r[2:0], r[5:3], r[8:6], r[31:16]);
        end
        for (int i = 0; i < 8; i++) ex(3'b000, 3'(i), 3'(i), 16'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_proc.md
Name: multicycle_proc

Overview:
- Parametrised successor to the current two-instruction processor: same run/din/bus/done contract, widened to N registers and an ALU datapath.
- Multi-cycle controller driven by a 2-bit step counter (t0..t3).
- Executes mv, mvi, add and sub over a single shared combinational bus.
- Sits as the processor core under the system top. Memory and PC logic stay outside it: instructions and immediates arrive on din.

Parameters:
- REG_WIDTH, 16: width of the data registers, bus and din.
- NUM_REGS, 8: number of general registers. Power of two, range 2..8.
- RIDX_WIDTH, $clog2(NUM_REGS): register index width. Derived; must not be overridden.
- INSTRUCTION_WIDTH, 3+2*RIDX_WIDTH: instruction word width, laid out as {opcode[2:0], X, Y}. Derived.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  start enable; sampled only in t0.
- din  input  REG_WIDTH  instruction word in t0 (low INSTRUCTION_WIDTH bits); immediate in mvi t1.
- bus  output  REG_WIDTH  shared datapath bus, combinational mux.
- done  output  1  combinational; high during the final step of an instruction.
- busy  output  1  registered; high while t != t0.

Behaviour:
- Reset (clk edge with rst=1):
  - R0..R(N-1), A, G, IR and t are cleared to 0.
  - busy=0. bus=0 and done=0 combinationally.
  - Reset mid-instruction aborts it; no register write occurs on that edge.
- t0:
  - bus=0, done=0.
  - run=1: IR<=din[INSTRUCTION_WIDTH-1:0], t<=t1.
  - run=0: t holds at t0.
- Opcode 000, mv Rx<-Ry:
  - t1: bus=Ry, done=1.
  - Edge: Rx<=bus, t<=t0.
- Opcode 001, mvi Rx<-D:
  - t1: bus=din, done=1.
  - Edge: Rx<=bus, t<=t0.
- Opcode 010, add Rx<-Rx+Ry:
  - t1: bus=Rx, A<=bus.
  - t2: bus=Ry, G<=A+bus.
  - t3: bus=G, done=1; Rx<=G, t<=t0.
- Opcode 011, sub Rx<-Rx-Ry: same sequence as add, with G<=A-bus in t2.
- Opcodes 100..111 (reserved):
  - t1: bus=0, done=1.
  - No write, t<=t0. Acts as a one-step NOP.
- Arithmetic:
  - Modulo 2^REG_WIDTH. Carry and borrow are discarded unless the optional feature is enabled.
  - X==Y is legal: add R1,R1 doubles R1; sub R1,R1 gives 0.
- run is ignored after t0. Deasserting run mid-instruction does not stall or abort it.
- Back-to-back: an instruction completes at the done edge. With run=1 held, the next IR load happens on the following t0 edge.
- Latency:
  - mv, mvi and reserved opcodes: 2 cycles from the IR-load edge... i.e. the t0 load edge plus one t1 edge.
  - add and sub: 4 cycles (t0..t3).
- Index bits above NUM_REGS-1 cannot occur, because RIDX_WIDTH is exact.
- done is never asserted in t0. busy deasserts on the edge where done is sampled.

Optional Feature:
- Macro: MULTICYCLE_PROC_FLAGS_EN.
- Defined:
  - Adds output ports flag_z (1 bit) and flag_c (1 bit), both reset to 0.
  - Flags update only on the t2 edge of add or sub.
  - flag_z = (result==0).
  - flag_c = carry-out for add, borrow for sub (A<Ry unsigned).
  - Flags hold their value otherwise.
- Not defined: ports are absent and no flag logic is generated.

Decomposition:
- Package proc_pkg holds:
  - Opcode localparams OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011.
  - Step encodings T0..T3 (2 bits).
  - Bus-select enum BUS_ZERO, BUS_REG, BUS_DIN, BUS_G.
- One sub-module, proc_regfile:
  - NUM_REGS x REG_WIDTH storage.
  - Synchronous write port (we, waddr, wdata); combinational read port (raddr, rdata).
  - Synchronous clear on rst.
- Controller FSM, A/G registers and the bus mux stay in multicycle_proc.

Test Plan:
- Reset then mvi R0,0x0005:
  - t1 shows bus=0x0005 with done=1.
  - mv R1,R0 then gives bus=0x0005 at t1.
- mvi R2,0x00A5; mvi R3,0x0010; add R2,R3:
  - t1 bus=0x00A5, t2 bus=0x0010, t3 bus=0x00B5 with done=1.
  - A following mv R4,R2 reads 0x00B5.
- mvi R5,0x0003; mvi R6,0x0005; sub R5,R6:
  - t3 bus=0xFFFE (wrap-around).
  - FLAGS_EN: flag_c=1, flag_z=0.
- mvi R7,0xFFFF; add R7,R7:
  - Result 0xFFFE.
  - FLAGS_EN: flag_c=1.
  - sub R7,R7 then gives 0x0000 with flag_z=1.
- run=0 in t0 for 5 cycles: t stays at t0, busy=0, no register changes. Drop run in t2 of an add: the add still completes at t3.
- Assert rst during t2 of add R0,R1: the edge after rst clears all registers, and a subsequent mv R2,R0 gives bus=0x0000. Also: reserved opcode 3'b111 gives done=1 at t1, bus=0, and no register modified.
